burst_ram_arbiter: RTL and testbench
====================================

// Module: burst_ram_arbiter
// PURPOSE
// Shares one BurstRAM command/data port between the instruction cache (port I) and the data cache (port D).
// Grants one whole burst transaction at a time (command plus all data beats) using round-robin priority.
// Sits between the icache/dcache br_* outputs and the BurstRAM controller, replacing a fixed static mux.
// PARAMETERS
// RAM_DEPTH_BITWIDTH       4   width of burst address
// RAM_BURST_DATA_COUNT     4   data beats per burst; must be >= 2
// RAM_BURST_DATA_BITWIDTH  64  width of one data beat
// PORTS
// clk             in   1    clock
// rst_n           in   1    asynchronous active-low reset
// i_cmd/d_cmd     in   1    requester command: 0 = read, 1 = write
// i_cmd_en/d_cmd_en in 1    requester command request
// i_addr/d_addr   in   RAM_DEPTH_BITWIDTH  burst address
// i_wr_data/d_wr_data in RAM_BURST_DATA_BITWIDTH  write beat
// i_data_mask/d_data_mask in RAM_BURST_DATA_BITWIDTH/8  byte mask (1 = masked)
// i_busy/d_busy   out  1    port may not issue; command is accepted only while this is 0
// i_rd_data_valid/d_rd_data_valid out 1  read beat valid for this port only
// rd_data         out  RAM_BURST_DATA_BITWIDTH  br_rd_data passed through to both ports
// grant           out  2    one-hot owner {D,I}; 00 when idle
// br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  to BurstRAM (widths as above)
// br_rd_data      in   RAM_BURST_DATA_BITWIDTH; br_rd_data_valid in 1; br_busy in 1
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, grant=00, beat counter=0, last_served=D (I wins the first tie).
//   br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=all ones.
//   i/d_rd_data_valid=0, i_busy=d_busy=1 while in reset.
// - States: IDLE, WRITE, READ.
// - IDLE: winner is computed combinationally (zero latency).
//   Only one port has cmd_en -> that port wins.
//   Both ports have cmd_en -> the port not equal to last_served wins.
//   Winner busy = br_busy. Loser busy = 1. Idle port with no request: busy = br_busy.
// - Acceptance: a command is accepted in the cycle where x_cmd_en=1 and x_busy=0.
//   In that cycle the winner's cmd/addr/wr_data/mask drive br_* and br_cmd_en=1.
//   On the next edge: last_served=winner, grant=winner, counter=0.
//   Then state goes to WRITE if cmd=1, else to READ.
// - The requester holds cmd_en, cmd, addr and the first beat stable until accepted.
// - WRITE: lasts exactly RAM_BURST_DATA_COUNT-1 cycles after acceptance.
//   br_wr_data/br_data_mask are driven from the owner. br_cmd_en=0.
//   Counter increments every cycle; the cycle with counter=COUNT-2 is the last one, then IDLE.
//   The owner presents beat k (k = 1..COUNT-1) in the k-th cycle after acceptance.
// - READ: br_rd_data_valid is routed to the owner's rd_data_valid only.
//   Counter increments on each valid; the valid with counter=COUNT-1 is the last beat, then IDLE.
// - In WRITE and READ: both busy outputs = 1 and br_cmd_en = 0.
// - Non-owner br_* fields: when no command and no write beat is active, drive the reset values above.
// - br_rd_data_valid while in IDLE or WRITE: dropped (neither port sees it). Counter is unchanged.
// - Minimum gap between accepted commands is 1 IDLE cycle, i.e. the earliest new accept is the cycle after the transaction ends.
// - Async reset mid-burst: the transaction is abandoned and state returns to IDLE. Requesters are reset by the same rst_n.
// - Counter width: $clog2(RAM_BURST_DATA_COUNT); it never wraps past COUNT-1.
// TESTING
// 1. I read at addr 3 alone -> accepted in the same cycle (br_cmd_en=1, br_addr=3, br_cmd=0).
//    Then 4 valids appear only on i_rd_data_valid; d_busy=1 throughout; back to IDLE after the 4th.
// 2. I and D both request from reset -> I granted first.
//    After I's burst, D (still holding its request) is granted. Then I and D alternate on repeated ties.
// 3. D writes to addr 5 with beats A,B,C,D -> br_wr_data=A in the accept cycle, then B,C,D on the next 3 cycles.
//    Mask follows d_data_mask; IDLE on the 4th cycle after accept.
// 4. br_busy=1 while I requests -> no br_cmd_en and i_busy=1. br_busy drops -> accepted that same cycle.
// 5. Stray br_rd_data_valid in IDLE -> no port valid asserted. The next read still counts exactly 4 beats.
// 6. rst_n pulsed low after 2 of 4 read beats -> grant=00 and IDLE immediately. A new D read then completes normally.

Source files
------------

// File: rtl/burst_ram_arbiter_if.sv
// BurstRAM-style command/data port bundle, used for both requester ports and the RAM side.
// Latency: none (wires only).
// Backpressure: master holds cmd_en/cmd/addr/first beat until it sees busy=0 in the same cycle.
// Ports (master view): out cmd, cmd_en, addr, wr_data, data_mask; in busy, rd_data_valid, rd_data.
interface burst_ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) ();
    localparam int MASK_W = DATA_W / 8;

    logic              cmd;
    logic              cmd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] data_mask;
    logic              busy;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  busy, rd_data_valid, rd_data
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output busy, rd_data_valid, rd_data
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM port between icache (I) and dcache (D), one whole burst per grant.
// Latency: zero in IDLE (winner's command reaches br_* combinationally); write data passes through combinationally.
// Backpressure: busy=1 to both ports during a burst; in IDLE the winner sees br busy, a losing requester sees 1.
// Ports: clk, rst_n; i_port/d_port (slave side of requesters); br (master side to BurstRAM); grant {D,I} one-hot.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    burst_ram_arbiter_if.slave   i_port,
    burst_ram_arbiter_if.slave   d_port,
    burst_ram_arbiter_if.master  br,
    output logic [1:0]           grant
);
    localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int CNT_W  = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(RAM_BURST_DATA_COUNT - 2);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t             state, state_nxt;
    logic [1:0]         grant_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last_d, last_d_nxt;   // 1: D was served last, so I wins the next tie
    logic               win_i, win_d, acc_i, acc_d;

    // Read data is broadcast; only the valid strobe is steered.
    assign i_port.rd_data = br.rd_data;
    assign d_port.rd_data = br.rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= 2'b00;
            cnt    <= '0;
            last_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            cnt    <= cnt_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        grant_nxt            = grant;
        cnt_nxt              = cnt;
        last_d_nxt           = last_d;
        acc_i                = 1'b0;
        acc_d                = 1'b0;
        i_port.busy          = 1'b1;
        d_port.busy          = 1'b1;
        i_port.rd_data_valid = 1'b0;
        d_port.rd_data_valid = 1'b0;
        br.cmd               = 1'b0;
        br.cmd_en            = 1'b0;
        br.addr              = '0;
        br.wr_data           = '0;
        br.data_mask         = {MASK_W{1'b1}};

        // D wins if it is the only requester, or on a tie when I was served last.
        win_d = d_port.cmd_en & (~i_port.cmd_en | ~last_d);
        win_i = i_port.cmd_en & ~win_d;

        case (state)
            IDLE: begin
                // rst_n gate keeps both ports busy while reset is asserted.
                if (rst_n) begin
                    i_port.busy = br.busy | (win_d & i_port.cmd_en);
                    d_port.busy = br.busy | (win_i & d_port.cmd_en);
                    acc_i = win_i & ~br.busy;
                    acc_d = win_d & ~br.busy;
                end
                if (acc_i) begin
                    br.cmd       = i_port.cmd;
                    br.cmd_en    = 1'b1;
                    br.addr      = i_port.addr;
                    br.wr_data   = i_port.wr_data;
                    br.data_mask = i_port.data_mask;
                end else if (acc_d) begin
                    br.cmd       = d_port.cmd;
                    br.cmd_en    = 1'b1;
                    br.addr      = d_port.addr;
                    br.wr_data   = d_port.wr_data;
                    br.data_mask = d_port.data_mask;
                end
                if (acc_i || acc_d) begin
                    grant_nxt  = {acc_d, acc_i};
                    last_d_nxt = acc_d;
                    cnt_nxt    = '0;
                    state_nxt  = (acc_d ? d_port.cmd : i_port.cmd) ? WRITE : READ;
                end
            end
            WRITE: begin
                // Beats 1..COUNT-1 follow the accept cycle back to back.
                if (grant[1]) begin
                    br.wr_data   = d_port.wr_data;
                    br.data_mask = d_port.data_mask;
                end else begin
                    br.wr_data   = i_port.wr_data;
                    br.data_mask = i_port.data_mask;
                end
                if (cnt == WR_LAST) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READ: begin
                i_port.rd_data_valid = br.rd_data_valid & grant[0];
                d_port.rd_data_valid = br.rd_data_valid & grant[1];
                if (br.rd_data_valid) begin
                    if (cnt == RD_LAST) begin
                        state_nxt = IDLE;
                        grant_nxt = 2'b00;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: reads, ties, writes, br busy stall, stray valids, mid-burst reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants.
module tb_burst_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 64;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    int         total;
    int         bad;

    burst_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_if ();
    burst_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();
    burst_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) br_if ();

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_COUNT(4),
        .RAM_BURST_DATA_BITWIDTH(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_port(i_if),
        .d_port(d_if),
        .br(br_if),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts just after a rising edge; ends on the falling edge of the first IDLE cycle.
    task automatic rd_burst(input logic [1:0] own, input bit gap);
        logic [63:0] beat;
        for (int k = 0; k < 4; k++) begin
            if (gap && k == 2) begin
                br_if.rd_data_valid = 1'b0;
                @(negedge clk);
                check("gap_grant", grant, own);
                check("gap_ivld", i_if.rd_data_valid, 1'b0);
                check("gap_dvld", d_if.rd_data_valid, 1'b0);
                tick();
            end
            beat = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
            br_if.rd_data       = beat;
            br_if.rd_data_valid = 1'b1;
            @(negedge clk);
            check("rd_ivld", i_if.rd_data_valid, own[0]);
            check("rd_dvld", d_if.rd_data_valid, own[1]);
            check("rd_idata", i_if.rd_data, beat);
            check("rd_ddata", d_if.rd_data, beat);
            check("rd_grant", grant, own);
            check("rd_ibusy", i_if.busy, 1'b1);
            check("rd_dbusy", d_if.busy, 1'b1);
            check("rd_cmden", br_if.cmd_en, 1'b0);
            tick();
        end
        br_if.rd_data_valid = 1'b0;
        @(negedge clk);
        check("rd_end_grant", grant, 2'b00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        i_if.cmd = 0; i_if.cmd_en = 0; i_if.addr = 0; i_if.wr_data = 0; i_if.data_mask = 0;
        d_if.cmd = 0; d_if.cmd_en = 0; d_if.addr = 0; d_if.wr_data = 0; d_if.data_mask = 0;
        br_if.busy = 0; br_if.rd_data = 0; br_if.rd_data_valid = 1'b1;

        // Reset values, with a request and a stray valid present.
        i_if.cmd_en = 1'b1;
        #3;
        check("rst_ibusy", i_if.busy, 1'b1);
        check("rst_dbusy", d_if.busy, 1'b1);
        check("rst_grant", grant, 2'b00);
        check("rst_cmden", br_if.cmd_en, 1'b0);
        check("rst_mask", br_if.data_mask, 8'hFF);
        check("rst_addr", br_if.addr, 4'd0);
        check("rst_ivld", i_if.rd_data_valid, 1'b0);
        i_if.cmd_en = 1'b0;
        br_if.rd_data_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 1: I reads addr 3 alone.
        i_if.cmd_en = 1'b1; i_if.cmd = 1'b0; i_if.addr = 4'd3;
        @(negedge clk);
        check("t1_cmden", br_if.cmd_en, 1'b1);
        check("t1_addr", br_if.addr, 4'd3);
        check("t1_cmd", br_if.cmd, 1'b0);
        check("t1_ibusy", i_if.busy, 1'b0);
        tick();
        i_if.cmd_en = 1'b0;
        rd_burst(2'b01, 1'b0);
        check("t1_idle_ibusy", i_if.busy, 1'b0);
        tick();

        // 2: tie from reset -> I first, then alternation.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        i_if.cmd_en = 1'b1; i_if.addr = 4'd1;
        d_if.cmd_en = 1'b1; d_if.addr = 4'd2; d_if.cmd = 1'b0;
        @(negedge clk);
        check("t2_addr_i", br_if.addr, 4'd1);
        check("t2_ibusy", i_if.busy, 1'b0);
        check("t2_dbusy", d_if.busy, 1'b1);
        tick();
        i_if.cmd_en = 1'b0;
        rd_burst(2'b01, 1'b0);
        check("t2_addr_d", br_if.addr, 4'd2);
        check("t2_dbusy2", d_if.busy, 1'b0);
        check("t2_cmden", br_if.cmd_en, 1'b1);
        tick();
        d_if.addr = 4'd6;
        i_if.cmd_en = 1'b1; i_if.addr = 4'd7;
        rd_burst(2'b10, 1'b0);
        check("t2_tie_i", br_if.addr, 4'd7);
        check("t2_tie_dbusy", d_if.busy, 1'b1);
        tick();
        i_if.cmd_en = 1'b0;
        rd_burst(2'b01, 1'b0);
        check("t2_tie_d", br_if.addr, 4'd6);
        tick();
        d_if.cmd_en = 1'b0;
        rd_burst(2'b10, 1'b0);
        tick();

        // 3: D writes addr 5, beats A..D, stray valid during the burst.
        d_if.cmd = 1'b1; d_if.cmd_en = 1'b1; d_if.addr = 4'd5;
        d_if.wr_data = 64'hAAAA; d_if.data_mask = 8'h0F;
        @(negedge clk);
        check("t3_cmden", br_if.cmd_en, 1'b1);
        check("t3_cmd", br_if.cmd, 1'b1);
        check("t3_addr", br_if.addr, 4'd5);
        check("t3_beatA", br_if.wr_data, 64'hAAAA);
        check("t3_maskA", br_if.data_mask, 8'h0F);
        tick();
        d_if.cmd_en = 1'b0; d_if.cmd = 1'b0;
        d_if.wr_data = 64'hBBBB; d_if.data_mask = 8'hF0;
        @(negedge clk);
        check("t3_beatB", br_if.wr_data, 64'hBBBB);
        check("t3_maskB", br_if.data_mask, 8'hF0);
        check("t3_cmden0", br_if.cmd_en, 1'b0);
        check("t3_grant", grant, 2'b10);
        check("t3_ibusy", i_if.busy, 1'b1);
        tick();
        d_if.wr_data = 64'hCCCC; d_if.data_mask = 8'h3C;
        br_if.rd_data_valid = 1'b1;
        @(negedge clk);
        check("t3_beatC", br_if.wr_data, 64'hCCCC);
        check("t3_wr_dvld", d_if.rd_data_valid, 1'b0);
        check("t3_wr_ivld", i_if.rd_data_valid, 1'b0);
        tick();
        br_if.rd_data_valid = 1'b0;
        d_if.wr_data = 64'hDDDD; d_if.data_mask = 8'hC3;
        @(negedge clk);
        check("t3_beatD", br_if.wr_data, 64'hDDDD);
        check("t3_maskD", br_if.data_mask, 8'hC3);
        check("t3_grantD", grant, 2'b10);
        tick();
        d_if.wr_data = 64'h0; d_if.data_mask = 8'h00;
        @(negedge clk);
        check("t3_end_grant", grant, 2'b00);
        check("t3_end_data", br_if.wr_data, 64'h0);
        check("t3_end_mask", br_if.data_mask, 8'hFF);
        check("t3_end_dbusy", d_if.busy, 1'b0);
        tick();

        // 5: stray valid in IDLE.
        br_if.rd_data_valid = 1'b1;
        @(negedge clk);
        check("t5_ivld", i_if.rd_data_valid, 1'b0);
        check("t5_dvld", d_if.rd_data_valid, 1'b0);
        check("t5_grant", grant, 2'b00);
        tick();
        br_if.rd_data_valid = 1'b0;

        // 4: br busy stalls I's request, then accept in the cycle busy drops.
        br_if.busy = 1'b1;
        i_if.cmd_en = 1'b1; i_if.cmd = 1'b0; i_if.addr = 4'd4;
        @(negedge clk);
        check("t4_cmden_stall", br_if.cmd_en, 1'b0);
        check("t4_ibusy_stall", i_if.busy, 1'b1);
        tick();
        @(negedge clk);
        check("t4_grant_stall", grant, 2'b00);
        br_if.busy = 1'b0;
        #1;
        check("t4_cmden", br_if.cmd_en, 1'b1);
        check("t4_ibusy", i_if.busy, 1'b0);
        check("t4_addr", br_if.addr, 4'd4);
        tick();
        i_if.cmd_en = 1'b0;
        rd_burst(2'b01, 1'b1);
        tick();

        // 6: reset after 2 of 4 beats, then a clean D read.
        i_if.cmd_en = 1'b1; i_if.addr = 4'd8;
        tick();
        i_if.cmd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            br_if.rd_data_valid = 1'b1;
            @(negedge clk);
            check("t6_ivld", i_if.rd_data_valid, 1'b1);
            tick();
        end
        br_if.rd_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant", grant, 2'b00);
        check("t6_rst_ibusy", i_if.busy, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        check("t6_idle_ibusy", i_if.busy, 1'b0);
        d_if.cmd_en = 1'b1; d_if.cmd = 1'b0; d_if.addr = 4'd9;
        @(negedge clk);
        check("t6_addr", br_if.addr, 4'd9);
        check("t6_cmden", br_if.cmd_en, 1'b1);
        tick();
        d_if.cmd_en = 1'b0;
        rd_burst(2'b10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
